// File: rtl/siso_frame_ctrl.sv
// siso_frame_ctrl: parallel-in, serial-out frame controller.
// Serializes a captured WIDTH-bit word as a frame on dout:
// start bit (0), data LSB first, optional even-parity bit, stop bit (1),
// then GAP idle-high cycles. The line idles at 1.
module siso_frame_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             parity_en,
    output logic             in_ready,
    output logic             dout,
    output logic             busy,
    output logic             frame_done
);

    // Bit counter is at least one bit wide so WIDTH=1 still elaborates.
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    // Last gap count; unused when GAP=0 because the GAP state is never entered.
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StGap
    } state_e;

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             par_en_q,  par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             dout_q,    dout_d;

    // State and datapath registers; reset returns the line to idle-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            dout_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            dout_q    <= dout_d;
        end
    end

    // Next-state logic; dout_d is the line value for the state being entered,
    // so the registered dout changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        dout_d    = dout_q;

        unique case (state_q)
            StIdle: begin
                dout_d = 1'b1;
                if (in_valid) begin
                    // Capture everything the frame needs; later input changes are ignored.
                    shreg_d   = in_data;
                    par_en_d  = parity_en;
                    par_bit_d = ^in_data;
                    bit_cnt_d = '0;
                    state_d   = StStart;
                    dout_d    = 1'b0;
                end
            end

            StStart: begin
                state_d   = StData;
                dout_d    = shreg_q[0];
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = '0;
            end

            StData: begin
                // bit_cnt_q indexes the bit currently on the line.
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (par_en_q) begin
                        state_d = StParity;
                        dout_d  = par_bit_q;
                    end else begin
                        state_d = StStop;
                        dout_d  = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    dout_d    = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                end
            end

            StParity: begin
                state_d = StStop;
                dout_d  = 1'b1;
            end

            StStop: begin
                dout_d    = 1'b1;
                gap_cnt_d = '0;
                if (GAP > 0) begin
                    state_d = StGap;
                end else begin
                    state_d = StIdle;
                end
            end

            StGap: begin
                dout_d = 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = StIdle;
                dout_d  = 1'b1;
            end
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        in_ready   = (state_q == StIdle);
        busy       = (state_q != StIdle);
        frame_done = (state_q == StStop);
        dout       = dout_q;
    end

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// tb_siso_frame_ctrl: directed stimulus with a scoreboard queue of expected
// {dout, frame_done} per busy cycle, popped by an independent monitor.
module tb_siso_frame_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned GAP   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             parity_en;
    logic             in_ready;
    logic             dout;
    logic             busy;
    logic             frame_done;

    int checks   = 0;
    int failures = 0;

    // Expected {dout, frame_done} for each busy cycle, in order.
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;

    siso_frame_ctrl #(
        .WIDTH(WIDTH),
        .GAP  (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .parity_en (parity_en),
        .in_ready  (in_ready),
        .dout      (dout),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line sequence for one frame: start, data LSB first, parity, stop, gap.
    task automatic push_frame(input logic [WIDTH-1:0] d, input logic p, input logic exp_par);
        exp_q.push_back(2'b00);
        for (int i = 0; i < int'(WIDTH); i++) exp_q.push_back({d[i], 1'b0});
        if (p) exp_q.push_back({exp_par, 1'b0});
        exp_q.push_back(2'b11);
        for (int i = 0; i < int'(GAP); i++) exp_q.push_back(2'b10);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic p, input logic exp_par);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_wait: in_ready got 0 expected 1 after %0d cycles", n);
        end
        in_valid  = 1'b1;
        in_data   = d;
        parity_en = p;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        // Disturb the inputs; the frame in flight must not notice.
        in_data   = ~d;
        parity_en = ~p;
        push_frame(d, p, exp_par);
    endtask

    // Count negedges with in_ready low until the controller is idle again.
    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: in_ready got 0 expected 1 after %0d cycles", n);
        end
    endtask

    // Monitor: every busy cycle must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset && busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_busy: got busy=1 dout=%0b expected idle", dout);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout_frame_done", {30'd0, dout, frame_done}, {30'd0, mon_e});
                check("in_ready_while_busy", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        parity_en = 1'b0;

        // Outputs held at idle values during and after reset.
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {28'd0, dout, in_ready, busy, frame_done}, 32'hC);
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_outputs", {28'd0, dout, in_ready, busy, frame_done}, 32'hC);
        end

        // 0xA5 without parity: 13-cycle frame, in_ready low 12 cycles.
        send(8'hA5, 1'b0, 1'b0);
        wait_idle(n);
        check("a5_ready_gap", n, 12);

        // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0.
        send(8'h07, 1'b1, 1'b1);
        wait_idle(n);
        check("07_ready_gap", n, 13);
        send(8'h03, 1'b1, 1'b0);
        wait_idle(n);
        check("03_ready_gap", n, 13);

        // Back-to-back with in_valid held high.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'h81;
        parity_en = 1'b0;
        @(posedge clk);
        #1;
        push_frame(8'h81, 1'b0, 1'b0);
        in_data = 8'h3C;
        wait_idle(n);
        check("b2b_ready_low", n, 12);
        @(posedge clk);
        #1;
        push_frame(8'h3C, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("b2b_second_accept", {31'd0, busy}, 32'd1);
        wait_idle(n);
        check("3c_ready_gap", n, 12);

        // in_valid pulsed with 0xFF during DATA of a 0x00 frame is ignored.
        send(8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle(n);
        repeat (4) @(negedge clk);
        check("ignored_word_queue", exp_q.size(), 0);

        // Asynchronous reset during DATA bit 3.
        send(8'hA5, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", {28'd0, dout, in_ready, busy, frame_done}, 32'hC);
        exp_q.delete();
        @(negedge clk);
        check("reset_hold", {28'd0, dout, in_ready, busy, frame_done}, 32'hC);
        @(negedge clk);
        // Release and request together: accept must happen on the first edge.
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        parity_en = 1'b0;
        @(posedge clk);
        #1;
        push_frame(8'h5A, 1'b0, 1'b0);
        in_valid = 1'b0;
        in_data  = 8'hA5;
        check("first_edge_accept", {31'd0, busy}, 32'd1);
        wait_idle(n);
        check("5a_ready_gap", n, 12);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/siso_frame_ctrl.md
SISO_FRAME_CTRL -- requirements
Module: siso_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data bits per frame, legal range 1..32.
REQ-002 Parameter GAP, default 2: idle-high cycles inserted after each stop bit, legal range 0..15.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: requester has a word on in_data.
REQ-006 Port in_data, input, WIDTH: parallel word to serialize.
REQ-007 Port parity_en, input, 1: adds an even-parity bit to the frame; sampled at accept.
REQ-008 Port in_ready, output, 1: controller can accept a word this cycle.
REQ-009 Port dout, output, 1: registered serial line; idle level is 1.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port frame_done, output, 1: one-cycle pulse during the STOP cycle.

Function
REQ-012 The block SHALL implement the FSM IDLE, START, DATA, PARITY, STOP, GAP.
REQ-013 in_ready SHALL equal 1 only in IDLE; this is a combinational function of the state.
REQ-014 Accept SHALL occur when in_valid and in_ready are both 1 at a rising clk edge.
- At accept: in_data goes into an internal WIDTH-bit shift register and parity_en into a flag.
- The FSM moves to START.
REQ-015 in_valid while busy SHALL be ignored; no data SHALL be captured and no state SHALL be disturbed.
REQ-016 dout SHALL be registered and SHALL take the value for the new state on the same edge as the state change.
REQ-017 START: dout=0 for exactly 1 cycle, then DATA.
REQ-018 DATA: dout SHALL present in_data LSB first, one bit per cycle, for exactly WIDTH cycles.
- The bit counter counts 0..WIDTH-1.
- After the last bit, go to PARITY if the captured flag is 1, else to STOP.
REQ-019 PARITY: dout = XOR of all captured data bits (even parity) for 1 cycle, then STOP.
REQ-020 STOP: dout=1 and frame_done=1 for 1 cycle.
- Next state is GAP if GAP>0, else IDLE.
REQ-021 GAP: dout=1 for exactly GAP cycles, then IDLE; the gap counter wraps to 0 on exit.
REQ-022 Frame spacing with in_valid held high SHALL be 1+1+WIDTH+P+1+GAP edges accept-to-accept, where P is the parity flag.
- With defaults and P=0 this is 13 cycles.
REQ-023 Changes on in_data or parity_en after accept SHALL NOT affect the frame in progress.
REQ-024 frame_done SHALL be 0 in every state other than STOP.

Reset
REQ-025 Reset SHALL act immediately, independent of clk, including mid-frame. While reset is asserted:
- state=IDLE
- dout=1
- in_ready=1
- busy=0
- frame_done=0
- shift register, counters and parity flag all cleared
REQ-026 After reset deasserts, an accept SHALL be possible on the first rising edge.

Verification
REQ-027 Reset with in_valid=0 -> dout=1, in_ready=1, busy=0, frame_done=0 held for 10 cycles.
REQ-028 Accept 0xA5 with parity_en=0 -> dout per cycle is 0,1,0,1,0,0,1,0,1,1.
- frame_done is high in the final 1 cycle.
- Then 2 idle cycles with dout=1, and in_ready returns to 1 on the 13th cycle after accept.
REQ-029 Accept 0x07 with parity_en=1 -> dout is 0,1,1,1,0,0,0,0,0, then parity 1, then stop 1.
- Accept 0x03 with parity_en=1 -> parity bit 0.
REQ-030 Hold in_valid=1 with 0x81 then 0x3C -> two complete frames, start bits 13 cycles apart.
- in_ready is low for all 12 intervening cycles.
REQ-031 Pulse in_valid with 0xFF during DATA of a 0x00 frame -> frame stays all-zero data bits and 0xFF is never transmitted.
REQ-032 Assert reset during DATA bit 3 -> dout=1 and busy=0 immediately.
- After release, accepting 0x5A yields a clean frame 0,0,1,0,1,1,0,1,0,1.
